dcache_line_mover: RTL and testbench

//  Line-granular initiator for the 64x128b D-cache data array SRAM (CS/OE/WEB/A/DI/DO).
//  - Refill: accepts 4 x 32b beats from the memory side and writes each beat into its word lane.
//  - Write-back: reads one 128b line and streams it out as 4 x 32b beats.
//  - Sits between the D-cache FSM / bus interface and the data array wrapper; owns the SRAM port while busy.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_line_buf.sv | 22 ++
 rtl/dcache_line_mover.sv | 147 ++++++++++++++
 tb/tb_dcache_line_mover.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared constants, FSM state type and byte-lane write-enable helper for the D-cache line mover.
package dcache_pkg;

  localparam int INDEX_W = 6;
  localparam int LINE_W  = 128;
  localparam int WORD_W  = 32;
  localparam int BEATS   = LINE_W / WORD_W;
  localparam int BEAT_W  = $clog2(BEATS);
  localparam int WEB_W   = LINE_W / 8;
  localparam int WORD_B  = WORD_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_SEND = 3'd4
  } mover_state_e;

  // Active-low byte enables: only the bytes of the selected word lane are written.
  function automatic logic [WEB_W-1:0] lane_web(input logic [BEAT_W-1:0] lane);
    logic [WEB_W-1:0] m;
    m = '0;
    m[WORD_B-1:0] = '1;
    return ~(m << (lane * WORD_B));
  endfunction

endpackage

// File: rtl/dcache_line_buf.sv
// Write-back line capture register with a word-lane output mux.
module dcache_line_buf
  import dcache_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cap,
  input  logic [LINE_W-1:0] i_line,
  input  logic [BEAT_W-1:0] i_sel,
  output logic [WORD_W-1:0] o_word
);

  logic [LINE_W-1:0] r_line;

  always_ff @(posedge i_clk) begin
    if (i_rst)      r_line <= '0;
    else if (i_cap) r_line <= i_line;
  end

  assign o_word = r_line[i_sel*WORD_W +: WORD_W];

endmodule

// File: rtl/dcache_line_mover.sv
// Line refill / write-back engine for the D-cache data array SRAM.
// Define DCACHE_CWF_EN to start refills at refill_word (critical word first).
module dcache_line_mover
  import dcache_pkg::*;
(
  input  logic               CK,
  input  logic               RST,
  input  logic               refill_start,
  input  logic [INDEX_W-1:0] refill_index,
  input  logic [1:0]         refill_word,
  input  logic               wb_start,
  input  logic [INDEX_W-1:0] wb_index,
  input  logic               fill_valid,
  output logic               fill_ready,
  input  logic [WORD_W-1:0]  fill_data,
  input  logic               fill_last,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [WORD_W-1:0]  wb_data,
  output logic               wb_last,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               sram_CS,
  output logic               sram_OE,
  output logic [WEB_W-1:0]   sram_WEB,
  output logic [INDEX_W-1:0] sram_A,
  output logic [LINE_W-1:0]  sram_DI,
  input  logic [LINE_W-1:0]  sram_DO
);

  mover_state_e       r_state;
  logic [BEAT_W-1:0]  r_beat_cnt;
  logic [INDEX_W-1:0] r_index;
  logic               r_done;
  logic               r_err;

  logic               w_fill_hs;
  logic               w_last_beat;
  logic [BEAT_W-1:0]  w_lane;
  logic [WORD_W-1:0]  w_buf_word;

  assign w_last_beat = (r_beat_cnt == BEAT_W'(BEATS - 1));
  // A reset cycle must never write the array, even with a beat presented.
  assign w_fill_hs   = (r_state == ST_FILL) && fill_valid && !RST;

`ifdef DCACHE_CWF_EN
  logic [1:0] r_word;
  always_ff @(posedge CK) begin
    if (RST)                                                r_word <= '0;
    else if (r_state == ST_IDLE && refill_start && !wb_start) r_word <= refill_word;
  end
  assign w_lane = r_word + r_beat_cnt;
`else
  logic w_unused_word;
  assign w_unused_word = ^refill_word;
  assign w_lane        = r_beat_cnt;
`endif

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_index    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_beat_cnt <= '0;
          if (wb_start) begin
            r_index <= wb_index;
            r_state <= ST_RD;
          end else if (refill_start) begin
            r_index <= refill_index;
            r_state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_fill_hs) begin
            // Early fill_last and a missing fill_last both close the line with an error.
            if (fill_last || w_last_beat) begin
              r_state    <= ST_IDLE;
              r_beat_cnt <= '0;
              r_done     <= 1'b1;
              r_err      <= !(fill_last && w_last_beat);
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        ST_RD:  r_state <= ST_CAP;
        ST_CAP: r_state <= ST_SEND;
        ST_SEND: begin
          if (wb_ready) begin
            if (w_last_beat) begin
              r_state    <= ST_IDLE;
              r_beat_cnt <= '0;
              r_done     <= 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  dcache_line_buf u_line_buf (
    .i_clk  (CK),
    .i_rst  (RST),
    .i_cap  (r_state == ST_CAP),
    .i_line (sram_DO),
    .i_sel  (r_beat_cnt),
    .o_word (w_buf_word)
  );

  always_comb begin
    sram_CS  = 1'b0;
    sram_OE  = 1'b0;
    sram_WEB = '1;
    sram_A   = '0;
    sram_DI  = '0;
    if (w_fill_hs) begin
      sram_CS  = 1'b1;
      sram_A   = r_index;
      sram_DI  = {BEATS{fill_data}};
      sram_WEB = lane_web(w_lane);
    end else if (r_state == ST_RD && !RST) begin
      sram_CS = 1'b1;
      sram_OE = 1'b1;
      sram_A  = r_index;
    end
  end

  assign fill_ready = (r_state == ST_FILL);
  assign wb_valid   = (r_state == ST_SEND);
  assign wb_last    = (r_state == ST_SEND) && w_last_beat;
  assign wb_data    = (r_state == ST_SEND) ? w_buf_word : '0;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_dcache_line_mover.sv
// Directed bench for dcache_line_mover with a behavioural 64x128b SRAM model.
module tb_dcache_line_mover;

  logic         CK = 1'b0;
  logic         RST;
  logic         refill_start;
  logic [5:0]   refill_index;
  logic [1:0]   refill_word;
  logic         wb_start;
  logic [5:0]   wb_index;
  logic         fill_valid;
  logic         fill_ready;
  logic [31:0]  fill_data;
  logic         fill_last;
  logic         wb_valid;
  logic         wb_ready;
  logic [31:0]  wb_data;
  logic         wb_last;
  logic         busy;
  logic         done;
  logic         err;
  logic         sram_CS;
  logic         sram_OE;
  logic [15:0]  sram_WEB;
  logic [5:0]   sram_A;
  logic [127:0] sram_DI;
  logic [127:0] sram_DO = '0;

  logic [127:0] mem [64];
  int n_chk = 0;
  int n_fail = 0;

  always #5 CK = ~CK;

  always_ff @(posedge CK) begin
    if (sram_CS) begin
      if (sram_OE) sram_DO <= mem[sram_A];
      else
        for (int b = 0; b < 16; b++)
          if (!sram_WEB[b]) mem[sram_A][b*8 +: 8] <= sram_DI[b*8 +: 8];
    end
  end

  dcache_line_mover dut (
    .CK(CK), .RST(RST),
    .refill_start(refill_start), .refill_index(refill_index), .refill_word(refill_word),
    .wb_start(wb_start), .wb_index(wb_index),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data), .fill_last(fill_last),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_last(wb_last),
    .busy(busy), .done(done), .err(err),
    .sram_CS(sram_CS), .sram_OE(sram_OE), .sram_WEB(sram_WEB), .sram_A(sram_A),
    .sram_DI(sram_DI), .sram_DO(sram_DO)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Offers n beats starting at base; webs holds the expected WEB per beat, beat 0 in the low 16 bits.
  task automatic refill(input logic [5:0] idx, input logic [1:0] word, input logic [31:0] base,
                        input int n, input int last_at, input logic [63:0] webs);
    refill_start = 1'b1;
    refill_index = idx;
    refill_word  = word;
    tick();
    refill_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      fill_valid = 1'b1;
      fill_data  = base + 32'(i);
      fill_last  = (i == last_at);
      #1;
      chk("fill_ready", fill_ready, 1'b1);
      chk("fill_web", sram_WEB, webs[i*16 +: 16]);
      chk("fill_A", sram_A, idx);
      chk("fill_DI", sram_DI, {4{base + 32'(i)}});
      tick();
    end
    fill_valid = 1'b0;
    fill_last  = 1'b0;
    #1;
  endtask

  initial begin
    RST = 1'b1;
    refill_start = 0; refill_index = 0; refill_word = 0;
    wb_start = 0; wb_index = 0;
    fill_valid = 0; fill_data = 0; fill_last = 0; wb_ready = 0;
    tick(); tick();

    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_fill_ready", fill_ready, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_last", wb_last, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_CS", sram_CS, 1'b0);
    chk("rst_OE", sram_OE, 1'b0);
    chk("rst_WEB", sram_WEB, 16'hFFFF);
    chk("rst_A", sram_A, 6'd0);
    chk("rst_DI", sram_DI, 128'h0);
    RST = 1'b0;
    tick();

    // Plain refill of set 5.
    refill(6'd5, 2'd0, 32'hAAAA0000, 4, 3, {16'h0FFF, 16'hF0FF, 16'hFF0F, 16'hFFF0});
    chk("r5_done", done, 1'b1);
    chk("r5_err", err, 1'b0);
    chk("r5_busy", busy, 1'b0);
    chk("r5_line", mem[5], 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000);
    tick();
    chk("r5_done_pulse", done, 1'b0);

    // Load set 9 with 33..22..11..00, then write it back.
    refill(6'd9, 2'd0, 32'h0, 4, 3, {16'h0FFF, 16'hF0FF, 16'hFF0F, 16'hFFF0});
    chk("r9_pre", mem[9][31:0], 32'h0);
    tick();
    mem[9] = 128'h33333333_22222222_11111111_00000000;
    wb_start = 1'b1;
    wb_index = 6'd9;
    tick();
    wb_start = 1'b0;
    #1;
    chk("wb_rd_CS", sram_CS, 1'b1);
    chk("wb_rd_OE", sram_OE, 1'b1);
    chk("wb_rd_A", sram_A, 6'd9);
    chk("wb_rd_WEB", sram_WEB, 16'hFFFF);
    chk("wb_rd_valid", wb_valid, 1'b0);
    tick();
    chk("wb_cap_valid", wb_valid, 1'b0);
    chk("wb_cap_CS", sram_CS, 1'b0);
    tick();
    chk("wb_b0_valid", wb_valid, 1'b1);
    chk("wb_b0_data", wb_data, 32'h00000000);
    chk("wb_b0_last", wb_last, 1'b0);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("wb_b1_stall_valid", wb_valid, 1'b1);
      chk("wb_b1_stall_data", wb_data, 32'h11111111);
      chk("wb_b1_stall_last", wb_last, 1'b0);
      if (s < 2) tick();
    end
    wb_ready = 1'b1;
    tick();
    chk("wb_b2_data", wb_data, 32'h22222222);
    chk("wb_b2_last", wb_last, 1'b0);
    tick();
    chk("wb_b3_data", wb_data, 32'h33333333);
    chk("wb_b3_last", wb_last, 1'b1);
    chk("wb_b3_done_early", done, 1'b0);
    tick();
    wb_ready = 1'b0;
    #1;
    chk("wb_done", done, 1'b1);
    chk("wb_err", err, 1'b0);
    chk("wb_valid_after", wb_valid, 1'b0);
    chk("wb_busy_after", busy, 1'b0);
    tick();

    // Simultaneous starts: write-back wins.
    wb_start = 1'b1; wb_index = 6'd9;
    refill_start = 1'b1; refill_index = 6'd7;
    tick();
    wb_start = 1'b0; refill_start = 1'b0;
    #1;
    chk("both_busy", busy, 1'b1);
    chk("both_fill_ready", fill_ready, 1'b0);
    chk("both_OE", sram_OE, 1'b1);
    chk("both_A", sram_A, 6'd9);
    wb_ready = 1'b1;
    begin
      int cyc = 0;
      while (!done && cyc < 12) begin
        chk("both_no_fill", fill_ready, 1'b0);
        tick();
        cyc++;
      end
      chk("both_done_seen", done, 1'b1);
    end
    wb_ready = 1'b0;
    tick();

    // Early fill_last on beat 1.
    refill(6'd12, 2'd0, 32'hBBBB0000, 2, 1, {32'hFFFF_FFFF, 16'hFF0F, 16'hFFF0});
    chk("early_done", done, 1'b1);
    chk("early_err", err, 1'b1);
    chk("early_busy", busy, 1'b0);
    chk("early_line", mem[12][63:0], 64'hBBBB0001_BBBB0000);
    fill_valid = 1'b1;
    #1;
    chk("early_no_accept", fill_ready, 1'b0);
    chk("early_no_write", sram_CS, 1'b0);
    fill_valid = 1'b0;
    tick();

    // Missing fill_last on beat 3.
    refill(6'd40, 2'd0, 32'hDDDD0000, 4, 9, {16'h0FFF, 16'hF0FF, 16'hFF0F, 16'hFFF0});
    chk("nolast_done", done, 1'b1);
    chk("nolast_err", err, 1'b1);
    fill_valid = 1'b1;
    #1;
    chk("nolast_no_accept", fill_ready, 1'b0);
    chk("nolast_no_write", sram_CS, 1'b0);
    fill_valid = 1'b0;
    tick();

    // refill_word = 2: wrapped order with critical word first, linear order otherwise.
`ifdef DCACHE_CWF_EN
    refill(6'd20, 2'd2, 32'hCCCC0000, 4, 3, {16'hFF0F, 16'hFFF0, 16'h0FFF, 16'hF0FF});
    chk("cwf_line", mem[20], 128'hCCCC0001_CCCC0000_CCCC0003_CCCC0002);
`else
    refill(6'd20, 2'd2, 32'hCCCC0000, 4, 3, {16'h0FFF, 16'hF0FF, 16'hFF0F, 16'hFFF0});
    chk("cwf_line", mem[20], 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000);
`endif
    chk("cwf_done", done, 1'b1);
    chk("cwf_err", err, 1'b0);
    tick();

    // Reset in the middle of a refill.
    refill_start = 1'b1; refill_index = 6'd30; refill_word = 2'd0;
    tick();
    refill_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fill_valid = 1'b1;
      fill_data  = 32'hEEEE0000 + 32'(i);
      tick();
    end
    fill_valid = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_CS", sram_CS, 1'b0);
    chk("mid_rst_WEB", sram_WEB, 16'hFFFF);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_line", mem[30][63:0], 64'hEEEE0001_EEEE0000);
    tick();
    chk("mid_rst_done2", done, 1'b0);
    refill(6'd31, 2'd0, 32'hFFFF0000, 4, 3, {16'h0FFF, 16'hF0FF, 16'hFF0F, 16'hFFF0});
    chk("post_rst_done", done, 1'b1);
    chk("post_rst_err", err, 1'b0);
    chk("post_rst_line", mem[31], 128'hFFFF0003_FFFF0002_FFFF0001_FFFF0000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
